raster_engine: RTL and testbench

Parametrised, pipelined successor to the single-triangle edge-function rasterizer. Holds `NUM_TRI` triangle slots, loaded through a valid/ready port and set up by a sequential FSM that precomputes edge coefficients. Slots are double-buffered so the displayed set only changes at frame boundaries. A 2-stage pixel pipeline reports per-slot coverage and the front-most slot for each streamed pixel, feeding the colour/output stage of the VGA path.

---
 rtl/raster_pkg.sv | 36 +++
 rtl/raster_edge_eval.sv | 56 +++++
 rtl/raster_engine.sv | 211 +++++++++++++++++++++
 tb/tb_raster_engine.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types for the triangle raster engine: setup FSM states, edge coefficients,
// triangle slots and the accumulator width derivation.
package raster_pkg;

  // Default geometry; coefficient storage is sized for it.
  localparam int DEF_COL_W = 10;
  localparam int DEF_ROW_W = 9;
  localparam int DEF_VX_W  = 7;
  localparam int DEF_VY_W  = 6;
  localparam int DEF_SHIFT = 3;

  function automatic int acc_w(input int col_w, input int row_w, input int vx_w,
                               input int vy_w, input int shift);
    return ((col_w > row_w) ? col_w : row_w) + ((vx_w > vy_w) ? vx_w : vy_w) + shift + 3;
  endfunction

  localparam int COEF_W = acc_w(DEF_COL_W, DEF_ROW_W, DEF_VX_W, DEF_VY_W, DEF_SHIFT);

  typedef enum logic [2:0] {
    IDLE, EDGE0, EDGE1, EDGE2, AREA, COMMIT
  } setup_state_e;

  // Two's-complement coefficients; readers reinterpret them with $signed.
  typedef struct packed {
    logic [COEF_W-1:0] a;
    logic [COEF_W-1:0] b;
    logic [COEF_W-1:0] c;
  } edge_coef_t;

  typedef struct packed {
    edge_coef_t [2:0] e;
    logic             en;
    logic             degen;
  } tri_slot_t;

endpackage

// File: rtl/raster_edge_eval.sv
// One triangle slot's pixel evaluation: stage 1 registers the edge products,
// stage 2 (combinational here, registered by the top) sums them and tests signs.
module raster_edge_eval
  import raster_pkg::*;
#(
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W,
  parameter int ACC_W = COEF_W
) (
  input  logic             clk,
  input  logic             vld_i,
  input  tri_slot_t        slot_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic             cull_i,
  output logic [2:0]       neg_o,
  output logic [2:0]       zero_o,
  output logic             hit_o
);

  logic signed [ACC_W-1:0] x_s, y_s;
  logic signed [ACC_W-1:0] pa_q [3];
  logic signed [ACC_W-1:0] pb_q [3];
  logic signed [ACC_W-1:0] c_q  [3];
  logic signed [ACC_W-1:0] e_s  [3];
  logic                    en_q, degen_q;
  logic                    pos_ok, neg_ok;

  assign x_s = $signed({{(ACC_W-COL_W){1'b0}}, col_i});
  assign y_s = $signed({{(ACC_W-ROW_W){1'b0}}, row_i});

  always_ff @(posedge clk) begin
    if (vld_i) begin
      for (int k = 0; k < 3; k++) begin
        pa_q[k] <= $signed(slot_i.e[k].a[ACC_W-1:0]) * y_s;
        pb_q[k] <= $signed(slot_i.e[k].b[ACC_W-1:0]) * x_s;
        c_q[k]  <= $signed(slot_i.e[k].c[ACC_W-1:0]);
      end
      en_q    <= slot_i.en;
      degen_q <= slot_i.degen;
    end
  end

  // Zero counts as inside for both windings.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      e_s[k]    = pa_q[k] - pb_q[k] + c_q[k];
      neg_o[k]  = e_s[k][ACC_W-1];
      zero_o[k] = (e_s[k] == '0);
    end
    pos_ok = ~|neg_o;
    neg_ok = &(neg_o | zero_o);
    hit_o  = en_q & ~degen_q & (pos_ok | (cull_i & neg_ok));
  end

endmodule

// File: rtl/raster_engine.sv
// Multi-slot edge-function rasterizer: sequential coefficient setup into a shadow bank,
// frame-synchronous bank swap, and a 2-stage per-pixel coverage pipeline.
module raster_engine
  import raster_pkg::*;
#(
  parameter int NUM_TRI = 2,
  parameter int VX_W    = DEF_VX_W,
  parameter int VY_W    = DEF_VY_W,
  parameter int COL_W   = DEF_COL_W,
  parameter int ROW_W   = DEF_ROW_W,
  parameter int SHIFT   = DEF_SHIFT,
  parameter int IDX_W   = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic               load_en,
  input  logic [VX_W-1:0]    load_v0x,
  input  logic [VX_W-1:0]    load_v1x,
  input  logic [VX_W-1:0]    load_v2x,
  input  logic [VY_W-1:0]    load_v0y,
  input  logic [VY_W-1:0]    load_v1y,
  input  logic [VY_W-1:0]    load_v2y,
  input  logic               cull_mode,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COL_W-1:0]   pix_col,
  input  logic [ROW_W-1:0]   pix_row,
  output logic               hit_valid,
  output logic [NUM_TRI-1:0] hit,
  output logic               hit_any,
  output logic [IDX_W-1:0]   hit_idx
);

  localparam int ACC_W  = acc_w(COL_W, ROW_W, VX_W, VY_W, SHIFT);
  localparam int STAGES = 2;

  // ---------------- setup FSM ----------------
  setup_state_e            state_q;
  logic                    ready_q;
  logic [VX_W-1:0]         vx_q [3];
  logic [VY_W-1:0]         vy_q [3];
  logic [IDX_W-1:0]        idx_q;
  logic                    en_q, degen_q;
  edge_coef_t              coef_q [3];
  edge_coef_t              coef_d;
  tri_slot_t               slot_d;

  logic signed [ACC_W-1:0] sx [3];
  logic signed [ACC_W-1:0] sy [3];
  logic [1:0]              p_sel, q_sel;
  logic signed [ACC_W-1:0] xp, yp, xq, yq, ea, eb;
  logic signed [ACC_W-1:0] ma0, mb0, ma1, mb1, prod0, prod1, area;
  logic                    commit;

  assign load_ready = ready_q;

  // One multiplier pair serves every edge and, in AREA, the E0(v2) test.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sx[k] = $signed({{(ACC_W-VX_W){1'b0}}, vx_q[k]}) <<< SHIFT;
      sy[k] = $signed({{(ACC_W-VY_W){1'b0}}, vy_q[k]}) <<< SHIFT;
    end
    p_sel = 2'd0;
    q_sel = 2'd1;
    case (state_q)
      EDGE1:   begin p_sel = 2'd1; q_sel = 2'd2; end
      EDGE2:   begin p_sel = 2'd2; q_sel = 2'd0; end
      default: ;
    endcase
    xp = sx[p_sel];
    yp = sy[p_sel];
    xq = sx[q_sel];
    yq = sy[q_sel];
    ea = xq - xp;
    eb = yq - yp;
    if (state_q == AREA) begin
      ma0 = $signed(coef_q[0].b[ACC_W-1:0]);
      mb0 = sx[2];
      ma1 = $signed(coef_q[0].a[ACC_W-1:0]);
      mb1 = sy[2];
    end else begin
      ma0 = eb;
      mb0 = xp;
      ma1 = ea;
      mb1 = yp;
    end
    prod0    = ma0 * mb0;
    prod1    = ma1 * mb1;
    area     = prod1 - prod0 + $signed(coef_q[0].c[ACC_W-1:0]);
    coef_d.a = COEF_W'(ea);
    coef_d.b = COEF_W'(eb);
    coef_d.c = COEF_W'(prod0 - prod1);
    for (int k = 0; k < 3; k++) slot_d.e[k] = coef_q[k];
    slot_d.en    = en_q;
    slot_d.degen = degen_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (load_valid && ready_q) begin
            vx_q[0] <= load_v0x;
            vx_q[1] <= load_v1x;
            vx_q[2] <= load_v2x;
            vy_q[0] <= load_v0y;
            vy_q[1] <= load_v1y;
            vy_q[2] <= load_v2y;
            idx_q   <= load_idx;
            en_q    <= load_en;
            ready_q <= 1'b0;
            state_q <= EDGE0;
          end
        end
        EDGE0:   begin coef_q[0] <= coef_d; state_q <= EDGE1; end
        EDGE1:   begin coef_q[1] <= coef_d; state_q <= EDGE2; end
        EDGE2:   begin coef_q[2] <= coef_d; state_q <= AREA;  end
        AREA:    begin degen_q <= (area == '0); state_q <= COMMIT; end
        COMMIT:  begin ready_q <= 1'b1; state_q <= IDLE; end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- slot banks ----------------
  tri_slot_t shadow_q [NUM_TRI];
  tri_slot_t active_q [NUM_TRI];

  assign commit = (state_q == COMMIT) && (int'(idx_q) < NUM_TRI);

  // Swap copies the pre-commit shadow, so a same-cycle COMMIT waits for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRI; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (frame_start) active_q <= shadow_q;
      if (commit) shadow_q[idx_q] <= slot_d;
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [STAGES-1:0]          vld_pipe;
  logic                       cull_q;
  logic [NUM_TRI-1:0]         hit_s2;
  logic [NUM_TRI-1:0][2:0]    edge_neg, edge_zero;
  logic [IDX_W-1:0]           pri_idx;
  logic [NUM_TRI-1:0]         hit_q;
  logic                       hit_any_q;
  logic [IDX_W-1:0]           hit_idx_q;
  logic                       unused_edge_flags;

  for (genvar i = 0; i < NUM_TRI; i++) begin : g_slot
    raster_edge_eval #(
      .COL_W (COL_W),
      .ROW_W (ROW_W),
      .ACC_W (ACC_W)
    ) u_eval (
      .clk    (clk),
      .vld_i  (pix_valid),
      .slot_i (active_q[i]),
      .col_i  (pix_col),
      .row_i  (pix_row),
      .cull_i (cull_q),
      .neg_o  (edge_neg[i]),
      .zero_o (edge_zero[i]),
      .hit_o  (hit_s2[i])
    );
  end

  // Per-edge flags are only kept for debug taps.
  assign unused_edge_flags = ^{edge_neg, edge_zero};

  always_comb begin
    pri_idx = '0;
    for (int i = NUM_TRI - 1; i >= 0; i--) begin
      if (hit_s2[i]) pri_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      cull_q    <= 1'b0;
      hit_q     <= '0;
      hit_any_q <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], pix_valid};
      if (pix_valid) cull_q <= cull_mode;
      hit_q     <= vld_pipe[0] ? hit_s2 : '0;
      hit_any_q <= vld_pipe[0] & (|hit_s2);
      hit_idx_q <= vld_pipe[0] ? pri_idx : '0;
    end
  end

  assign hit_valid = vld_pipe[STAGES-1];
  assign hit       = hit_q;
  assign hit_any   = hit_any_q;
  assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_raster_engine.sv
// Directed bench for raster_engine: setup latency, coverage, winding, degeneracy,
// slot priority, frame-swap timing and reset abort.
module tb_raster_engine;

  localparam int NUM_TRI = 2;
  localparam int VX_W    = 7;
  localparam int VY_W    = 6;
  localparam int COL_W   = 10;
  localparam int ROW_W   = 9;
  localparam int IDX_W   = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_valid = 1'b0;
  logic               load_ready;
  logic [IDX_W-1:0]   load_idx = '0;
  logic               load_en = 1'b0;
  logic [VX_W-1:0]    load_v0x = '0, load_v1x = '0, load_v2x = '0;
  logic [VY_W-1:0]    load_v0y = '0, load_v1y = '0, load_v2y = '0;
  logic               cull_mode = 1'b0;
  logic               frame_start = 1'b0;
  logic               pix_valid = 1'b0;
  logic [COL_W-1:0]   pix_col = '0;
  logic [ROW_W-1:0]   pix_row = '0;
  logic               hit_valid;
  logic [NUM_TRI-1:0] hit;
  logic               hit_any;
  logic [IDX_W-1:0]   hit_idx;

  int checks = 0;
  int errors = 0;
  int lat;

  raster_engine #(
    .NUM_TRI (NUM_TRI), .VX_W (VX_W), .VY_W (VY_W),
    .COL_W (COL_W), .ROW_W (ROW_W), .SHIFT (3)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .load_valid (load_valid), .load_ready (load_ready),
    .load_idx (load_idx), .load_en (load_en),
    .load_v0x (load_v0x), .load_v1x (load_v1x), .load_v2x (load_v2x),
    .load_v0y (load_v0y), .load_v1y (load_v1y), .load_v2y (load_v2y),
    .cull_mode (cull_mode), .frame_start (frame_start),
    .pix_valid (pix_valid), .pix_col (pix_col), .pix_row (pix_row),
    .hit_valid (hit_valid), .hit (hit), .hit_any (hit_any), .hit_idx (hit_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one load request; returns after the accepting edge.
  task automatic issue(input int idx, input logic en, input int x0, input int y0,
                       input int x1, input int y1, input int x2, input int y2);
    int n = 0;
    while (!load_ready && n < 20) begin tick(); n++; end
    chk("issue.ready", 32'(load_ready), 32'd1);
    load_idx = IDX_W'(idx);
    load_en  = en;
    load_v0x = VX_W'(x0); load_v0y = VY_W'(y0);
    load_v1x = VX_W'(x1); load_v1y = VY_W'(y1);
    load_v2x = VX_W'(x2); load_v2y = VY_W'(y2);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load(input int idx, input logic en, input int x0, input int y0,
                      input int x1, input int y1, input int x2, input int y2);
    issue(idx, en, x0, y0, x1, y1, x2, y2);
    lat = 0;
    while (!load_ready && lat < 20) begin tick(); lat++; end
    chk("load.busy_cycles", 32'(lat), 32'd5);
  endtask

  task automatic swap;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pix(input string tag, input int c, input int r, input logic cm,
                     input logic [NUM_TRI-1:0] eh, input logic [IDX_W-1:0] ei);
    pix_valid = 1'b1;
    pix_col   = COL_W'(c);
    pix_row   = ROW_W'(r);
    cull_mode = cm;
    tick();
    pix_valid = 1'b0;
    tick();
    chk({tag, ".hit_valid"}, 32'(hit_valid), 32'd1);
    chk({tag, ".hit"},       32'(hit),       32'(eh));
    chk({tag, ".hit_any"},   32'(hit_any),   32'(|eh));
    chk({tag, ".hit_idx"},   32'(hit_idx),   32'(ei));
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst.load_ready", 32'(load_ready), 32'd0);
    chk("rst.hit_valid",  32'(hit_valid),  32'd0);
    chk("rst.hit",        32'(hit),        32'd0);
    chk("rst.hit_any",    32'(hit_any),    32'd0);
    chk("rst.hit_idx",    32'(hit_idx),    32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.load_ready", 32'(load_ready), 32'd1);

    // Triangle A in slot 0: inside at (267,187), outside at (0,0)
    load(0, 1'b1, 60, 10, 30, 50, 10, 10);
    pix("pre_swap", 267, 187, 1'b0, 2'b00, 1'b0);
    swap();
    pix("triA.in", 267, 187, 1'b0, 2'b01, 1'b0);
    tick();
    chk("idle.hit_valid", 32'(hit_valid), 32'd0);
    chk("idle.hit",       32'(hit),       32'd0);
    pix("triA.out", 0, 0, 1'b0, 2'b00, 1'b0);

    // Reversed winding: only cull_mode=1 accepts it
    load(0, 1'b1, 60, 10, 10, 10, 30, 50);
    swap();
    pix("cw.cull0", 267, 187, 1'b0, 2'b00, 1'b0);
    pix("cw.cull1", 267, 187, 1'b1, 2'b01, 1'b0);

    // Collinear vertices: all edge values are zero at (160,160) but the slot is degenerate
    load(0, 1'b1, 10, 10, 20, 20, 30, 30);
    swap();
    pix("degen.cull0", 160, 160, 1'b0, 2'b00, 1'b0);
    pix("degen.cull1", 160, 160, 1'b1, 2'b00, 1'b0);

    // Overlap and priority
    load(0, 1'b1, 60, 10, 30, 50, 10, 10);
    load(1, 1'b1, 60, 10, 30, 50, 10, 10);
    swap();
    pix("both", 267, 187, 1'b0, 2'b11, 1'b0);
    load(0, 1'b0, 60, 10, 30, 50, 10, 10);
    swap();
    pix("slot1_only", 267, 187, 1'b0, 2'b10, 1'b1);

    // COMMIT coinciding with frame_start lands in shadow only
    issue(1, 1'b0, 60, 10, 30, 50, 10, 10);
    tick(); tick(); tick(); tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("coincide.ready", 32'(load_ready), 32'd1);
    pix("coincide.old", 267, 187, 1'b0, 2'b10, 1'b1);
    swap();
    pix("coincide.new", 267, 187, 1'b0, 2'b00, 1'b0);

    // Reset during EDGE1 aborts the load and clears both banks
    load(1, 1'b1, 60, 10, 30, 50, 10, 10);
    swap();
    pix("pre_abort", 267, 187, 1'b0, 2'b10, 1'b1);
    issue(0, 1'b1, 60, 10, 30, 50, 10, 10);
    tick();
    rst_n = 1'b0;
    tick(); tick();
    chk("abort.rst_ready", 32'(load_ready), 32'd0);
    chk("abort.rst_hit_valid", 32'(hit_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort.ready", 32'(load_ready), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    swap();
    pix("abort.cleared", 267, 187, 1'b0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
